// File: rtl/conv_lyr_pkg.sv
// Shared constants, types and the ternary weight rule for the conv_lyr123 pipeline.
package conv_lyr_pkg;

    localparam int ACT_W = 4;
    localparam int N_CH  = 64;
    localparam int ACC_W = 14;

    typedef logic [N_CH-1:0][ACT_W-1:0] act_vec_t;
    typedef logic signed [ACC_W-1:0]    acc_t;

    // Ternary weight for layer l, output channel o, tap k, input element i: -1, 0 or +1.
    function automatic int wgt(input int l, input int o, input int k, input int i);
        return ((o + k + 2 * i + l) % 3) - 1;
    endfunction

endpackage

// File: rtl/tconv_lyr.sv
// One ternary conv layer: 3-tap window, constant-weight accumulate, ReLU, shift, 4-bit requantise.
// Define CONV_SAT_EN to clamp oversized activations to the maximum code instead of wrapping.
module tconv_lyr
    import conv_lyr_pkg::*;
#(
    parameter int LYR       = 1,
    parameter int N_IN      = 4,
    parameter int IN_W      = 8,
    parameter bit IN_SIGNED = 1'b1,
    parameter int SHIFT     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 vld_in,
    input  logic [N_IN*IN_W-1:0] data_in,
    output logic                 vld_out,
    output act_vec_t             data_out
);

    typedef logic [N_IN*IN_W-1:0] in_vec_t;

    // win[0] is the previous valid vector (tap 1), win[1] the one before (tap 2).
    in_vec_t  win [2];
    in_vec_t  taps [3];
    acc_t     elems [3][N_IN];
    acc_t     acc_nxt [N_CH];
    acc_t     acc_q [N_CH];
    logic     vld_s1;
    act_vec_t quant_nxt;

    assign taps[0] = data_in;
    assign taps[1] = win[0];
    assign taps[2] = win[1];

    for (genvar gk = 0; gk < 3; gk++) begin : g_tap
        for (genvar gi = 0; gi < N_IN; gi++) begin : g_elem
            assign elems[gk][gi] = {{(ACC_W-IN_W){IN_SIGNED & taps[gk][gi*IN_W+IN_W-1]}},
                                    taps[gk][gi*IN_W +: IN_W]};
        end
    end

    // Weights fold to constants after unrolling, so each channel is an add/subtract tree.
    always_comb begin
        for (int o = 0; o < N_CH; o++) begin
            acc_nxt[o] = '0;
            for (int k = 0; k < 3; k++) begin
                for (int i = 0; i < N_IN; i++) begin
                    if (wgt(LYR, o, k, i) == 1) begin
                        acc_nxt[o] = acc_nxt[o] + elems[k][i];
                    end else if (wgt(LYR, o, k, i) == -1) begin
                        acc_nxt[o] = acc_nxt[o] - elems[k][i];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win    <= '{default: '0};
            acc_q  <= '{default: '0};
            vld_s1 <= 1'b0;
        end else begin
            vld_s1 <= vld_in;
            if (vld_in) begin
                win[0] <= data_in;
                win[1] <= win[0];
                acc_q  <= acc_nxt;
            end
        end
    end

    function automatic logic [ACT_W-1:0] requant(input acc_t a);
        acc_t r;
        r = a[ACC_W-1] ? '0 : (a >> SHIFT);
`ifdef CONV_SAT_EN
        return (r > acc_t'((1 << ACT_W) - 1)) ? {ACT_W{1'b1}} : ACT_W'(r);
`else
        return ACT_W'(r);
`endif
    endfunction

    always_comb begin
        quant_nxt = '0;
        for (int o = 0; o < N_CH; o++) begin
            quant_nxt[o] = requant(acc_q[o]);
        end
    end

    // Output register only loads on valid so the last vector holds through gaps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_out  <= 1'b0;
            data_out <= '0;
        end else begin
            vld_out <= vld_s1;
            if (vld_s1) begin
                data_out <= quant_nxt;
            end
        end
    end

endmodule

// File: rtl/conv_lyr123.sv
// Three-layer ternary 1-D conv front end: 2x I/Q samples in, 64 x 4-bit activations out, 6-cycle latency.
// CONV_SAT_EN selects saturating (defined) or wrapping (undefined) requantisation in every layer.
module conv_lyr123
    import conv_lyr_pkg::*;
#(
    parameter int SHIFT1 = 4,
    parameter int SHIFT2 = 5,
    parameter int SHIFT3 = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    vld_in,
    input  logic [1:0][7:0]         data_in [1:0],
    output logic                    vld_out,
    output logic [N_CH*ACT_W-1:0]   data_out
);

    logic [31:0] x1;
    logic        vld1;
    logic        vld2;
    act_vec_t    act1;
    act_vec_t    act2;
    act_vec_t    act3;

    // Element i = 2t + c lands at bits [8i+7:8i].
    assign x1 = {data_in[1][1], data_in[1][0], data_in[0][1], data_in[0][0]};

    tconv_lyr #(
        .LYR(1), .N_IN(4), .IN_W(8), .IN_SIGNED(1'b1), .SHIFT(SHIFT1)
    ) lyr1 (
        .clk(clk), .rst(rst), .vld_in(vld_in), .data_in(x1),
        .vld_out(vld1), .data_out(act1)
    );

    tconv_lyr #(
        .LYR(2), .N_IN(N_CH), .IN_W(ACT_W), .IN_SIGNED(1'b0), .SHIFT(SHIFT2)
    ) lyr2 (
        .clk(clk), .rst(rst), .vld_in(vld1), .data_in(act1),
        .vld_out(vld2), .data_out(act2)
    );

    tconv_lyr #(
        .LYR(3), .N_IN(N_CH), .IN_W(ACT_W), .IN_SIGNED(1'b0), .SHIFT(SHIFT3)
    ) lyr3 (
        .clk(clk), .rst(rst), .vld_in(vld2), .data_in(act2),
        .vld_out(vld_out), .data_out(act3)
    );

    assign data_out = act3;

endmodule

// File: tb/tb_conv_lyr123.sv
// Scoreboard bench for conv_lyr123: directed vectors, reference model of all three layers,
// plus hand-computed checks at the lyr1 boundary. Follows CONV_SAT_EN like the design.
module tb_conv_lyr123;

    localparam int LAT = 6;
`ifdef CONV_SAT_EN
    localparam logic [3:0] SAT_V = 4'd15;
`else
    localparam logic [3:0] SAT_V = 4'd7;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           vld_in;
    logic [1:0][7:0] data_in [1:0];
    logic           vld_out;
    logic [255:0]   data_out;

    always #5 clk = ~clk;

    conv_lyr123 dut (
        .clk(clk), .rst(rst), .vld_in(vld_in), .data_in(data_in),
        .vld_out(vld_out), .data_out(data_out)
    );

    typedef struct {
        logic [255:0] data;
        int           cyc;
    } exp_t;

    exp_t         top_q [$];
    exp_t         l1_q [$];
    exp_t         mon_e;
    logic [255:0] last_exp = '0;
    int           n_cmp = 0;
    int           n_err = 0;
    int           cyc = 0;
    int           mw [3][3][64];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("[TB] FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic checkValue(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("[TB] FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    function automatic int sx(input logic signed [7:0] v);
        return v;
    endfunction

    function automatic logic [255:0] rotVec(input int m, input logic [3:0] v);
        logic [255:0] r;
        r = '0;
        for (int o = 0; o < 64; o++) begin
            if (o % 3 == m) r[4*o +: 4] = v;
        end
        return r;
    endfunction

    function automatic logic [3:0] refQuant(input int acc, input int sh);
        int r;
        r = (acc > 0) ? (acc >> sh) : 0;
`ifdef CONV_SAT_EN
        if (r > 15) r = 15;
`endif
        return 4'(r & 15);
    endfunction

    task automatic modelReset();
        foreach (mw[a, b, c]) mw[a][b][c] = 0;
    endtask

    task automatic modelVector(input int x0, input int x1, input int x2, input int x3,
                               output logic [255:0] y);
        int cur [64];
        int nxt [64];
        int acc;
        int n;
        cur = '{default: 0};
        nxt = '{default: 0};
        cur[0] = x0; cur[1] = x1; cur[2] = x2; cur[3] = x3;
        for (int l = 1; l <= 3; l++) begin
            n = (l == 1) ? 4 : 64;
            for (int i = 0; i < 64; i++) begin
                mw[l-1][2][i] = mw[l-1][1][i];
                mw[l-1][1][i] = mw[l-1][0][i];
                mw[l-1][0][i] = cur[i];
            end
            for (int o = 0; o < 64; o++) begin
                acc = 0;
                for (int k = 0; k < 3; k++) begin
                    for (int i = 0; i < n; i++) begin
                        acc += (((o + k + 2 * i + l) % 3) - 1) * mw[l-1][k][i];
                    end
                end
                nxt[o] = int'(refQuant(acc, (l == 1) ? 4 : 5));
            end
            cur = nxt;
        end
        y = '0;
        for (int o = 0; o < 64; o++) y[4*o +: 4] = 4'(cur[o]);
    endtask

    task automatic applyStimulus(input bit v, input logic [7:0] x0, input logic [7:0] x1,
                                 input logic [7:0] x2, input logic [7:0] x3);
        exp_t e;
        @(posedge clk); #1;
        vld_in = v;
        data_in[0][0] = x0; data_in[0][1] = x1;
        data_in[1][0] = x2; data_in[1][1] = x3;
        if (v) begin
            modelVector(sx(x0), sx(x1), sx(x2), sx(x3), e.data);
            e.cyc = cyc;
            top_q.push_back(e);
        end
    endtask

    task automatic pushL1(input logic [255:0] v);
        exp_t e;
        e.data = v;
        e.cyc  = cyc;
        l1_q.push_back(e);
    endtask

    task automatic doReset();
        @(posedge clk); #1;
        rst = 1'b0;
        vld_in = 1'b0;
        #1;
        checkValue("rst_vld_out", int'(vld_out), 0);
        checkOutput("rst_data_out", data_out, '0);
        top_q.delete();
        l1_q.delete();
        modelReset();
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        @(posedge clk); #1;
        vld_in = 1'b0;
        while ((top_q.size() != 0 || l1_q.size() != 0) && n < 50) begin
            @(posedge clk);
            n++;
        end
        checkValue("drain", top_q.size() + l1_q.size(), 0);
    endtask

    // Monitor: pops on every output pulse, checks data and latency, checks hold in gaps.
    always @(negedge clk) begin
        if (!rst) begin
            last_exp = '0;
        end else begin
            if (vld_out) begin
                if (top_q.size() == 0) begin
                    checkValue("spurious_vld_out", int'(vld_out), 0);
                end else begin
                    mon_e = top_q.pop_front();
                    checkOutput("data_out", data_out, mon_e.data);
                    checkValue("latency", cyc - mon_e.cyc, LAT);
                    last_exp = mon_e.data;
                end
            end else begin
                checkOutput("hold", data_out, last_exp);
            end
            if (dut.lyr1.vld_out && l1_q.size() != 0) begin
                mon_e = l1_q.pop_front();
                checkOutput("lyr1_out", dut.lyr1.data_out, mon_e.data);
                checkValue("lyr1_latency", cyc - mon_e.cyc, 2);
            end
        end
    end

    initial begin
        logic [15:0] w0;
        logic [15:0] w1;
        rst = 1'b0;
        vld_in = 1'b0;
        data_in[0] = '0;
        data_in[1] = '0;
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        checkValue("reset_vld_out", int'(vld_out), 0);
        checkOutput("reset_data_out", data_out, '0);
        @(posedge clk); #1;
        rst = 1'b1;

        $display("[TB] zero stream");
        for (int n = 0; n < 8; n++) applyStimulus(1'b1, 8'd0, 8'd0, 8'd0, 8'd0);
        waitDrain();

        $display("[TB] single impulse");
        doReset();
        applyStimulus(1'b1, 8'd127, 8'd0, 8'd0, 8'd0); pushL1(rotVec(1, 4'd7));
        applyStimulus(1'b1, 8'd0, 8'd0, 8'd0, 8'd0);   pushL1(rotVec(0, 4'd7));
        applyStimulus(1'b1, 8'd0, 8'd0, 8'd0, 8'd0);   pushL1(rotVec(2, 4'd7));
        applyStimulus(1'b1, 8'd0, 8'd0, 8'd0, 8'd0);   pushL1('0);
        applyStimulus(1'b1, 8'd0, 8'd0, 8'd0, 8'd0);   pushL1('0);
        waitDrain();

        $display("[TB] requantisation overflow");
        doReset();
        applyStimulus(1'b1, 8'd127, 8'd0, 8'h80, 8'd127); pushL1(rotVec(1, SAT_V));
        applyStimulus(1'b1, 8'd0, 8'd0, 8'd0, 8'd0);      pushL1(rotVec(0, SAT_V));
        applyStimulus(1'b1, 8'd0, 8'd0, 8'd0, 8'd0);      pushL1(rotVec(2, SAT_V));
        applyStimulus(1'b1, 8'd0, 8'd0, 8'd0, 8'd0);      pushL1('0);
        waitDrain();

        $display("[TB] valid gaps");
        doReset();
        applyStimulus(1'b1, 8'd10, 8'd20, 8'hE2, 8'd40);
        applyStimulus(1'b0, 8'h55, 8'h55, 8'h55, 8'h55);
        applyStimulus(1'b1, 8'hF9, 8'd90, 8'd33, 8'h9C);
        applyStimulus(1'b1, 8'd60, 8'hC4, 8'd5, 8'd120);
        applyStimulus(1'b0, 8'h7F, 8'h7F, 8'h7F, 8'h7F);
        waitDrain();

        $display("[TB] mid-stream reset");
        doReset();
        for (int n = 0; n < 8; n++) begin
            applyStimulus(1'b1, 8'(20 * n + 7), 8'(100 - 9 * n), 8'(-3 * n), 8'(5 * n + 50));
        end
        doReset();
        for (int n = 0; n < 8; n++) applyStimulus(1'b1, 8'd0, 8'd0, 8'd0, 8'd0);
        waitDrain();

        $display("[TB] ramp");
        doReset();
        for (int n = 0; n < 16; n++) begin
            w0 = 16'(2 + 2 * n);
            w1 = 16'(1 + 2 * n);
            applyStimulus(1'b1, w0[7:0], w0[15:8], w1[7:0], w1[15:8]);
        end
        waitDrain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
